mips_mc_core: RTL and testbench

Self-contained multicycle MIPS core that merges the multicycle datapath with its own control state machine, so the top level only connects memory. Memory is accessed through a ready/valid-style handshake instead of assuming single-cycle memory, and instruction fetch and data access share one port. It runs a fixed integer subset and halts cleanly on `syscall` or on an unsupported opcode. It replaces the external-control datapath plus separate controller in the lab top level.

---
 rtl/mips_mc_core.sv | 201 ++++++++++++++++++++
 tb/tb_mips_mc_core.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_mc_core.sv
// mips_mc_core: multicycle MIPS core with its own control FSM. Instruction fetch
// and data access share one ready/valid-style memory port.
// Ports: clk, rst (sync, active-low); memory port mem_addr/mem_rd_en/mem_wr_en/
//   mem_wr_data/mem_rd_data/mem_ready; debug pc/instr/state; status halted/illegal/mem_err.
// Optional feature: define MIPS_MC_LINK_EN to enable jal/jr (otherwise they halt as illegal).
module mips_mc_core #(
  parameter logic [31:0] RESET_PC = 32'h00400000,
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] mem_addr,
  output logic        mem_rd_en,
  output logic        mem_wr_en,
  output logic [31:0] mem_wr_data,
  input  logic [31:0] mem_rd_data,
  input  logic        mem_ready,
  output logic [31:0] pc,
  output logic [31:0] instr,
  output logic [3:0]  state,
  output logic        halted,
  output logic        illegal,
  output logic        mem_err
);

  localparam logic [5:0] OP_RTYPE = 6'h00, OP_J = 6'h02, OP_BEQ = 6'h04, OP_BNE = 6'h05;
  localparam logic [5:0] OP_ADDI = 6'h08, OP_LW = 6'h23, OP_SW = 6'h2B;
  localparam logic [5:0] FN_SLL = 6'h00, FN_SRL = 6'h02, FN_SYSCALL = 6'h0C, FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22, FN_AND = 6'h24, FN_OR = 6'h25, FN_SLT = 6'h2A;
`ifdef MIPS_MC_LINK_EN
  localparam logic [5:0] OP_JAL = 6'h03, FN_JR = 6'h08;
`endif
  localparam int WW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);

  typedef enum logic [3:0] {
    S_FETCH = 4'd0, S_DECODE = 4'd1, S_MEMADR = 4'd2, S_MEMRD = 4'd3, S_MEMWB = 4'd4,
    S_MEMWR = 4'd5, S_EXEC = 4'd6, S_RWB = 4'd7, S_ADDIEX = 4'd8, S_IWB = 4'd9,
    S_BRANCH = 4'd10, S_JUMP = 4'd11, S_HALT = 4'd12
  } state_t;

  state_t        cur_st, nxt_st;
  logic [31:0]   pc_q, ir_q, a_q, b_q, aluout_q, mdr_q, alu_res;
  logic [31:0]   rf [32];
  logic [WW-1:0] wait_cnt;
  logic          wait_tick, timeout, bad_op;

  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd, shamt;
  logic [31:0] imm_sext, br_off, jmp_tgt;

  assign op       = ir_q[31:26];
  assign rs       = ir_q[25:21];
  assign rt       = ir_q[20:16];
  assign rd       = ir_q[15:11];
  assign shamt    = ir_q[10:6];
  assign funct    = ir_q[5:0];
  assign imm_sext = {{16{ir_q[15]}}, ir_q[15:0]};
  assign br_off   = {{14{ir_q[15]}}, ir_q[15:0], 2'b00};
  assign jmp_tgt  = {pc_q[31:28], ir_q[25:0], 2'b00};

  assign pc          = pc_q;
  assign instr       = ir_q;
  assign state       = cur_st;
  assign halted      = (cur_st == S_HALT);
  assign mem_wr_data = b_q;
  assign mem_addr    = (cur_st == S_FETCH) ? pc_q : aluout_q;
  // A stall only ends the run once the budget of MAX_WAIT wait cycles is spent.
  assign timeout     = wait_tick && (wait_cnt == WW'(MAX_WAIT));

  always_ff @(posedge clk) begin
    if (!rst) cur_st <= S_FETCH;
    else      cur_st <= nxt_st;
  end

  always_comb begin
    nxt_st    = cur_st;
    mem_rd_en = 1'b0;
    mem_wr_en = 1'b0;
    wait_tick = 1'b0;
    bad_op    = 1'b0;
    case (cur_st)
      S_FETCH: begin
        // Enables are gated by rst so nothing is requested in a reset cycle.
        mem_rd_en = rst;
        if (mem_ready) nxt_st = S_DECODE;
        else           wait_tick = 1'b1;
      end
      S_DECODE: begin
        case (op)
          OP_RTYPE: begin
            case (funct)
              FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT, FN_SLL, FN_SRL: nxt_st = S_EXEC;
`ifdef MIPS_MC_LINK_EN
              FN_JR:      nxt_st = S_JUMP;
`endif
              FN_SYSCALL: nxt_st = S_HALT;
              default: begin
                nxt_st = S_HALT;
                bad_op = 1'b1;
              end
            endcase
          end
          OP_ADDI:       nxt_st = S_ADDIEX;
          OP_LW, OP_SW:  nxt_st = S_MEMADR;
          OP_BEQ, OP_BNE: nxt_st = S_BRANCH;
          OP_J:          nxt_st = S_JUMP;
`ifdef MIPS_MC_LINK_EN
          OP_JAL:        nxt_st = S_JUMP;
`endif
          default: begin
            nxt_st = S_HALT;
            bad_op = 1'b1;
          end
        endcase
      end
      S_MEMADR: nxt_st = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD: begin
        mem_rd_en = rst;
        if (mem_ready) nxt_st = S_MEMWB;
        else           wait_tick = 1'b1;
      end
      S_MEMWR: begin
        mem_wr_en = rst;
        if (mem_ready) nxt_st = S_FETCH;
        else           wait_tick = 1'b1;
      end
      S_MEMWB, S_RWB, S_IWB, S_BRANCH, S_JUMP: nxt_st = S_FETCH;
      S_EXEC:   nxt_st = S_RWB;
      S_ADDIEX: nxt_st = S_IWB;
      S_HALT:   nxt_st = S_HALT;
      default:  nxt_st = S_HALT;
    endcase
    if (timeout) nxt_st = S_HALT;
  end

  always_comb begin
    alu_res = '0;
    case (funct)
      FN_ADD:  alu_res = a_q + b_q;
      FN_SUB:  alu_res = a_q - b_q;
      FN_AND:  alu_res = a_q & b_q;
      FN_OR:   alu_res = a_q | b_q;
      FN_SLT:  alu_res = {31'd0, $signed(a_q) < $signed(b_q)};
      FN_SLL:  alu_res = b_q << shamt;
      FN_SRL:  alu_res = b_q >> shamt;
      default: alu_res = '0;
    endcase
  end

  // $0 is never written, so after reset it always reads as zero.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_q     <= RESET_PC;
      ir_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      aluout_q <= '0;
      mdr_q    <= '0;
      wait_cnt <= '0;
      illegal  <= 1'b0;
      mem_err  <= 1'b0;
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else begin
      wait_cnt <= wait_tick ? wait_cnt + WW'(1) : '0;
      if (bad_op)  illegal <= 1'b1;
      if (timeout) mem_err <= 1'b1;
      case (cur_st)
        S_FETCH: if (mem_ready) begin
          ir_q <= mem_rd_data;
          pc_q <= pc_q + 32'd4;
        end
        S_DECODE: begin
          a_q      <= rf[rs];
          b_q      <= rf[rt];
          aluout_q <= pc_q + br_off;
        end
        S_MEMADR, S_ADDIEX: aluout_q <= a_q + imm_sext;
        S_MEMRD:  if (mem_ready) mdr_q <= mem_rd_data;
        S_MEMWB:  if (rt != 5'd0) rf[rt] <= mdr_q;
        S_EXEC:   aluout_q <= alu_res;
        S_RWB:    if (rd != 5'd0) rf[rd] <= aluout_q;
        S_IWB:    if (rt != 5'd0) rf[rt] <= aluout_q;
        S_BRANCH: begin
          // aluout_q holds the target computed in DECODE.
          if ((op == OP_BEQ) == ((a_q - b_q) == 32'd0)) pc_q <= aluout_q;
        end
        S_JUMP: begin
          if (op == OP_J) pc_q <= jmp_tgt;
`ifdef MIPS_MC_LINK_EN
          else if (op == OP_JAL) begin
            pc_q   <= jmp_tgt;
            rf[31] <= pc_q;
          end else pc_q <= a_q;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_mc_core.sv
module tb_mips_mc_core;
  localparam logic [31:0] RPC = 32'h00400000;

  logic        clk = 1'b0, rst = 1'b0;
  logic [31:0] mem_addr, mem_wr_data, pc, instr;
  logic [31:0] mem_rd_data = 32'h0;
  logic        mem_rd_en, mem_wr_en, halted, illegal, mem_err;
  logic        mem_ready = 1'b1;
  logic [3:0]  state;

  mips_mc_core #(.RESET_PC(RPC), .MAX_WAIT(15)) dut (
    .clk(clk), .rst(rst), .mem_addr(mem_addr), .mem_rd_en(mem_rd_en),
    .mem_wr_en(mem_wr_en), .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data),
    .mem_ready(mem_ready), .pc(pc), .instr(instr), .state(state), .halted(halted),
    .illegal(illegal), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; logic [31:0] data; } wr_t;
  typedef struct { logic [15:0] i1; logic [15:0] i2; logic [4:0] sh; logic [5:0] fn; logic [31:0] exp; } vec_t;

  wr_t         exp_q[$];
  wr_t         sb_e;
  logic [31:0] mem [logic [31:0]];
  logic [31:0] pc_hist [0:63];
  int          n_pass = 0, n_total = 0, viol = 0, stall_cnt = 0;
  logic [3:0]  stall_st = 4'd0;
  vec_t        vt [10];
  int          he;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [4:0] sh, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, sh, fn};
  endfunction

  task automatic load(input logic [31:0] off, input logic [31:0] w);
    mem[RPC + off] = w;
  endtask

  task automatic push_wr(input logic [31:0] a, input logic [31:0] d);
    wr_t w;
    w.addr = a;
    w.data = d;
    exp_q.push_back(w);
  endtask

  // Memory model: answers at negedge+1, optional stalls in one chosen state,
  // and pops the expected-write scoreboard on every accepted write.
  always @(negedge clk) begin
    #1;
    if (mem_rd_en && mem_wr_en) viol++;
    if ((mem_rd_en || mem_wr_en) && !(state inside {4'd0, 4'd3, 4'd5})) viol++;
    if ((mem_rd_en || mem_wr_en) && state == stall_st && stall_cnt > 0) begin
      mem_ready = 1'b0;
      stall_cnt--;
    end else begin
      mem_ready = 1'b1;
    end
    mem_rd_data = mem.exists(mem_addr) ? mem[mem_addr] : 32'h0;
    if (mem_wr_en && mem_ready) begin
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL extra_write: got write of 0x%08h to 0x%08h, expected none", mem_wr_data, mem_addr);
      end else begin
        sb_e = exp_q.pop_front();
        chk("wr_addr", mem_addr, sb_e.addr);
        chk("wr_data", mem_wr_data, sb_e.data);
        mem[mem_addr] = mem_wr_data;
      end
    end
  end

  task automatic do_reset;
    @(negedge clk);
    rst = 1'b0;
    mem.delete();
    exp_q.delete();
    stall_cnt = 0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  // Releases reset and counts edges until HALT; -1 if the bound expires.
  task automatic run_prog(input int max_edges, output int halt_edge);
    @(negedge clk);
    rst = 1'b1;
    halt_edge = -1;
    for (int e = 1; e <= max_edges; e++) begin
      @(posedge clk);
      #1;
      if (e < 64) pc_hist[e] = pc;
      if (halted) begin
        halt_edge = e;
        break;
      end
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation still running, expected to finish");
    $fatal(1);
  end

  initial begin
    int st_n [3];
    int st_he [3];
    vt[0] = '{16'd5,    16'd7,    5'd0, 6'h20, 32'h0000000C};
    vt[1] = '{16'hFFFF, 16'h0001, 5'd0, 6'h20, 32'h00000000};
    vt[2] = '{16'd5,    16'd7,    5'd0, 6'h22, 32'hFFFFFFFE};
    vt[3] = '{16'h8000, 16'h7FFF, 5'd0, 6'h22, 32'hFFFF0001};
    vt[4] = '{16'h00FF, 16'h0FF0, 5'd0, 6'h24, 32'h000000F0};
    vt[5] = '{16'h00FF, 16'h0FF0, 5'd0, 6'h25, 32'h00000FFF};
    vt[6] = '{16'hFFFF, 16'h0001, 5'd0, 6'h2A, 32'h00000001};
    vt[7] = '{16'h0001, 16'hFFFF, 5'd0, 6'h2A, 32'h00000000};
    vt[8] = '{16'h1234, 16'h0FF0, 5'd4, 6'h00, 32'h0000FF00};
    vt[9] = '{16'h1234, 16'hFFFF, 5'd4, 6'h02, 32'h0FFFFFFF};
    st_n  = '{3, 15, 16};
    st_he = '{14, 26, 19};

    // Unsupported opcode (lui)
    do_reset;
    load(0, itype(6'h0F, 5'd0, 5'd8, 16'h1234));
    run_prog(50, he);
    chk("illop_halt_edge", he, 2);
    chk("illop_illegal", illegal, 1'b1);
    chk("illop_pc", pc, RPC + 32'd4);
    chk("illop_mem_err", mem_err, 1'b0);

    // Unsupported funct (addu) after a legal instruction; the sw after it must not run
    do_reset;
    load(0, itype(6'h08, 5'd0, 5'd8, 16'd5));
    load(4, rtype(5'd8, 5'd8, 5'd9, 5'd0, 6'h21));
    load(8, itype(6'h2B, 5'd0, 5'd8, 16'h0100));
    run_prog(50, he);
    chk("illfn_halt_edge", he, 6);
    chk("illfn_illegal", illegal, 1'b1);
    chk("illfn_pc", pc, RPC + 32'd8);

    // Reset values and the first fetch
    do_reset;
    chk("rst_state", state, 4'd0);
    chk("rst_pc", pc, RPC);
    chk("rst_instr", instr, 32'h0);
    chk("rst_halted", halted, 1'b0);
    chk("rst_illegal", illegal, 1'b0);
    chk("rst_mem_err", mem_err, 1'b0);
    chk("rst_rd_en", mem_rd_en, 1'b0);
    chk("rst_wr_en", mem_wr_en, 1'b0);
    load(0, itype(6'h08, 5'd0, 5'd8, 16'd5));
    @(negedge clk);
    rst = 1'b1;
    #2;
    chk("fetch1_rd_en", mem_rd_en, 1'b1);
    chk("fetch1_addr", mem_addr, RPC);
    @(posedge clk);
    #1;
    chk("fetch1_pc", pc, RPC + 32'd4);
    chk("fetch1_instr", instr, 32'h20080005);
    chk("fetch1_state", state, 4'd1);

    // ALU table: addi $8; addi $9; op $10,$8,$9; sw $10,0x100($0); syscall
    for (int i = 0; i < 10; i++) begin
      do_reset;
      load(0,  itype(6'h08, 5'd0, 5'd8, vt[i].i1));
      load(4,  itype(6'h08, 5'd0, 5'd9, vt[i].i2));
      load(8,  rtype(5'd8, 5'd9, 5'd10, vt[i].sh, vt[i].fn));
      load(12, itype(6'h2B, 5'd0, 5'd10, 16'h0100));
      load(16, 32'h0000000C);
      push_wr(32'h100, vt[i].exp);
      run_prog(100, he);
      chk("alu_halt_edge", he, 18);
      chk("alu_sb_drained", exp_q.size(), 0);
    end

    // lw with wait states in MEMRD: 3, MAX_WAIT, MAX_WAIT+1
    for (int i = 0; i < 3; i++) begin
      do_reset;
      load(0, itype(6'h23, 5'd0, 5'd8, 16'h0300));
      load(4, itype(6'h2B, 5'd0, 5'd8, 16'h0100));
      load(8, 32'h0000000C);
      mem[32'h300] = 32'hDEADBEEF;
      if (st_n[i] <= 15) push_wr(32'h100, 32'hDEADBEEF);
      stall_st = 4'd3;
      stall_cnt = st_n[i];
      run_prog(100, he);
      chk("lw_halt_edge", he, st_he[i]);
      chk("lw_mem_err", mem_err, (st_n[i] > 15) ? 1'b1 : 1'b0);
      chk("lw_sb_drained", exp_q.size(), 0);
    end
    stall_cnt = 0;

    // Branch loop: bne equal -> not taken, beq equal at +0x10 back to +0x04
    do_reset;
    load(0,  itype(6'h08, 5'd0, 5'd12, 16'd1));
    load(4,  itype(6'h08, 5'd10, 5'd10, 16'd1));
    load(8,  itype(6'h05, 5'd12, 5'd12, 16'd10));
    load(12, itype(6'h2B, 5'd0, 5'd10, 16'h0100));
    load(16, itype(6'h04, 5'd10, 5'd12, 16'hFFFC));
    load(20, 32'h0000000C);
    push_wr(32'h100, 32'd1);
    push_wr(32'h100, 32'd2);
    run_prog(100, he);
    chk("br_halt_edge", he, 34);
    chk("br_bne_pc", pc_hist[11], RPC + 32'h0C);
    chk("br_beq_pc", pc_hist[18], RPC + 32'h04);
    chk("br_sb_drained", exp_q.size(), 0);

    // jal / jr
    do_reset;
    load(0,    {6'h03, 26'h0100008});
    load(4,    itype(6'h2B, 5'd0, 5'd31, 16'h0200));
    load(8,    32'h0000000C);
    load(32,   rtype(5'd31, 5'd0, 5'd0, 5'd0, 6'h08));
`ifdef MIPS_MC_LINK_EN
    push_wr(32'h200, RPC + 32'd4);
    run_prog(100, he);
    chk("jal_halt_edge", he, 12);
    chk("jal_pc", pc_hist[3], RPC + 32'h20);
    chk("jr_pc", pc_hist[6], RPC + 32'h04);
    chk("jal_illegal", illegal, 1'b0);
`else
    run_prog(100, he);
    chk("jal_halt_edge", he, 2);
    chk("jal_illegal", illegal, 1'b1);
    chk("jal_pc", pc, RPC + 32'd4);
`endif
    chk("jal_sb_drained", exp_q.size(), 0);

    // Reset asserted while a store waits in MEMWR
    do_reset;
    load(0, itype(6'h08, 5'd0, 5'd8, 16'd9));
    load(4, itype(6'h2B, 5'd0, 5'd8, 16'h0100));
    stall_st = 4'd5;
    stall_cnt = 10;
    @(negedge clk);
    rst = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    chk("mwr_state", state, 4'd5);
    @(negedge clk);
    rst = 1'b0;
    #2;
    chk("mwr_rst_wr_en", mem_wr_en, 1'b0);
    @(posedge clk);
    #1;
    chk("mwr_rst_state", state, 4'd0);
    chk("mwr_rst_pc", pc, RPC);
    stall_cnt = 0;
    repeat (2) @(posedge clk);
    #1;

    chk("enable_rules", viol, 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
